pmem_line_responder: RTL and testbench

PMEM_LINE_RESPONDER -- requirements
Module: pmem_line_responder

---
 rtl/pmem_line_responder_pkg.sv | 6 +
 rtl/pmem_line_responder_if.sv | 25 ++
 rtl/pmem_line_responder_beat_counter.sv | 35 +++
 rtl/pmem_line_responder.sv | 64 ++++++
 tb/tb_pmem_line_responder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pmem_line_responder_pkg.sv
// pmem_line_responder_pkg: shared FSM state, line width and watchdog limit.
package pmem_line_responder_pkg;
    localparam int LINE_W = 256;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
endpackage

// File: rtl/pmem_line_responder_if.sv
// pmem_line_responder_if: cache-line side and physical burst side of the responder.
interface pmem_line_responder_if #(parameter int BEAT_W = 64);
    import pmem_line_responder_pkg::*;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [LINE_W-1:0] pmem_rdata;
    logic              burst_read;
    logic              burst_write;
    logic [31:0]       burst_address;
    logic [BEAT_W-1:0] burst_wdata;
    logic [BEAT_W-1:0] burst_rdata;
    logic              burst_resp;
    logic              burst_err;
    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
        output pmem_resp, pmem_rdata, burst_read, burst_write, burst_address, burst_wdata, burst_err
    );
    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
        input  pmem_resp, pmem_rdata, burst_read, burst_write, burst_address, burst_wdata, burst_err
    );
endinterface

// File: rtl/pmem_line_responder_beat_counter.sv
// pmem_beat_counter: beat index within a burst plus optional stall watchdog.
// Watchdog present only when PMEM_BURST_TIMEOUT_EN is defined.
module pmem_beat_counter
    import pmem_line_responder_pkg::*;
#(
    parameter int BEATS = 4,
    parameter int CW = BEATS > 1 ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          active,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last,
    output logic          timeout
);
    logic step;
    assign step = active && inc;
    assign last = count == CW'(BEATS - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count <= '0;
        else if (clear) count <= '0;
        else if (step) count <= count + 1'b1;
`ifdef PMEM_BURST_TIMEOUT_EN
    logic [7:0] wd;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wd <= '0;
        else if (clear || step) wd <= '0;
        else if (active) wd <= wd + 8'd1;
    assign timeout = active && wd == TIMEOUT_LIMIT;
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: splits 256-bit line reads/writes into BEAT_W-wide physical bursts.
// Define PMEM_BURST_TIMEOUT_EN to abort stalled bursts via a watchdog and sticky burst_err.
module pmem_line_responder
    import pmem_line_responder_pkg::*;
#(
    parameter int BEAT_W = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    pmem_line_responder_if.slave bus
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    state_t            state, next;
    logic [31:0]       addr;
    logic [LINE_W-1:0] wline, rbuf, rline, fill;
    logic [CW-1:0]     count;
    logic              last, timeout, active, err;
    assign active = state == RD_BURST || state == WR_BURST;
    pmem_beat_counter #(.BEATS(BEATS), .CW(CW)) u_cnt (
        .clk(clk), .rst_n(rst_n), .clear(state == IDLE), .active(active),
        .inc(bus.burst_resp), .count(count), .last(last), .timeout(timeout)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        fill = rbuf;
        fill[count*BEAT_W +: BEAT_W] = bus.burst_rdata;
        if (state == IDLE) next = bus.pmem_write ? WR_BURST : bus.pmem_read ? RD_BURST : IDLE;
        else if (state == DONE) next = IDLE;
        else if (timeout || (bus.burst_resp && last)) next = DONE;
    end
    // Beats assemble in rbuf; the visible line only changes when the last beat lands.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr  <= '0;
            wline <= '0;
            rbuf  <= '0;
            rline <= '0;
        end else begin
            if (state == IDLE && (bus.pmem_write || bus.pmem_read)) addr <= {bus.pmem_address[31:5], 5'd0};
            if (state == IDLE && bus.pmem_write) wline <= bus.pmem_wdata;
            if (state == RD_BURST && bus.burst_resp) begin
                rbuf <= fill;
                if (last) rline <= fill;
            end
        end
`ifdef PMEM_BURST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err <= 1'b0;
        else if (timeout) err <= 1'b1;
`else
    assign err = 1'b0;
`endif
    assign bus.burst_read    = state == RD_BURST;
    assign bus.burst_write   = state == WR_BURST;
    assign bus.burst_address = addr;
    assign bus.burst_wdata   = wline[count*BEAT_W +: BEAT_W];
    assign bus.pmem_resp     = state == DONE;
    assign bus.pmem_rdata    = rline;
    assign bus.burst_err     = err;
endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder: directed and randomized line transactions against a line-level model.
module tb_pmem_line_responder;
    import pmem_line_responder_pkg::*;
    localparam int BEAT_W = 64;
    localparam int BEATS = LINE_W / BEAT_W;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int compared = 0;
    int mismatched = 0;
    logic [LINE_W-1:0] exp_rdata = '0;

    pmem_line_responder_if #(.BEAT_W(BEAT_W)) bus ();
    pmem_line_responder #(.BEAT_W(BEAT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] beat_of(input logic [LINE_W-1:0] l, input int k);
        return BEAT_W'(l >> (k * BEAT_W));
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // One full line transaction; the bench plays physical memory with `gap` idle cycles before each beat.
    task automatic xact(input bit rd, input bit wr, input logic [31:0] a, input logic [LINE_W-1:0] wd,
                        input int gap, input bit pattern, input bit noisy);
        logic [LINE_W-1:0] line;
        logic [BEAT_W-1:0] b;
        bit is_wr;
        logic [31:0] ba;
        line = '0;
        is_wr = wr;
        ba = a & 32'hFFFF_FFE0;
        bus.pmem_read = rd;
        bus.pmem_write = wr;
        bus.pmem_address = a;
        bus.pmem_wdata = wd;
        @(negedge clk);
        for (int k = 0; k < BEATS; k++) begin
            b = pattern ? {8{8'(17 * (k + 1))}} : {$urandom, $urandom};
            for (int g = 0; g <= gap; g++) begin
                chk("burst_read", bus.burst_read, !is_wr);
                chk("burst_write", bus.burst_write, is_wr);
                chk("burst_address", bus.burst_address, ba);
                chk("resp_busy", bus.pmem_resp, 1'b0);
                chk("rdata_hold", bus.pmem_rdata, exp_rdata);
                if (is_wr) chk("burst_wdata", bus.burst_wdata, beat_of(wd, k));
                if (noisy) begin
                    bus.pmem_wdata = rand_line();
                    bus.pmem_address = $urandom;
                    bus.pmem_read = 1'($urandom);
                    bus.pmem_write = 1'($urandom);
                end
                if (g == gap) begin
                    bus.burst_resp = 1'b1;
                    bus.burst_rdata = b;
                end
                @(negedge clk);
                bus.burst_resp = 1'b0;
                bus.burst_rdata = {$urandom, $urandom};
            end
            line = line | (LINE_W'(b) << (k * BEAT_W));
        end
        if (!is_wr) exp_rdata = line;
        chk("resp_done", bus.pmem_resp, 1'b1);
        chk("read_low_done", bus.burst_read, 1'b0);
        chk("write_low_done", bus.burst_write, 1'b0);
        chk("rdata_done", bus.pmem_rdata, exp_rdata);
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        @(negedge clk);
        chk("resp_one_cycle", bus.pmem_resp, 1'b0);
        chk("idle_read", bus.burst_read, 1'b0);
    endtask

    initial begin
        bit seen;
        int n;
        bus.pmem_read = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata = '0;
        bus.burst_rdata = '0;
        bus.burst_resp = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp", bus.pmem_resp, 1'b0);
        chk("rst_read", bus.burst_read, 1'b0);
        chk("rst_write", bus.burst_write, 1'b0);
        chk("rst_rdata", bus.pmem_rdata, '0);
        chk("rst_err", bus.burst_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        xact(1'b1, 1'b0, 32'h0000_1234, '0, 0, 1'b1, 1'b0);
        chk("pattern_line", exp_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
        xact(1'b0, 1'b1, 32'h0000_0080, rand_line(), 3, 1'b0, 1'b0);
        xact(1'b1, 1'b1, $urandom, rand_line(), 1, 1'b0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            bit w;
            w = 1'($urandom);
            xact(!w, w, $urandom, rand_line(), $urandom_range(0, 3), 1'b0, 1'($urandom));
        end

        for (int i = 0; i < 3; i++) begin
            bus.burst_resp = 1'b1;
            bus.burst_rdata = {$urandom, $urandom};
            @(negedge clk);
            chk("stray_resp", bus.pmem_resp, 1'b0);
            chk("stray_rdata", bus.pmem_rdata, exp_rdata);
            chk("stray_read", bus.burst_read, 1'b0);
        end
        bus.burst_resp = 1'b0;
        xact(1'b1, 1'b0, 32'h0000_4000, '0, 0, 1'b1, 1'b0);

        bus.pmem_read = 1'b1;
        bus.pmem_address = 32'h0000_9000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bus.burst_resp = 1'b1;
            bus.burst_rdata = {$urandom, $urandom};
            @(negedge clk);
            bus.burst_resp = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_read", bus.burst_read, 1'b0);
        chk("midrst_resp", bus.pmem_resp, 1'b0);
        chk("midrst_rdata", bus.pmem_rdata, '0);
        chk("midrst_err", bus.burst_err, 1'b0);
        exp_rdata = '0;
        bus.pmem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b1, 1'b0, 32'h0000_9000, '0, 1, 1'b0, 1'b0);

        bus.pmem_read = 1'b1;
        bus.pmem_address = 32'h0000_A000;
        @(negedge clk);
`ifdef PMEM_BURST_TIMEOUT_EN
        n = 0;
        while (!bus.pmem_resp && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 256);
        chk("timeout_err", bus.burst_err, 1'b1);
        chk("timeout_rdata", bus.pmem_rdata, exp_rdata);
        bus.pmem_read = 1'b0;
        @(negedge clk);
        chk("err_sticky", bus.burst_err, 1'b1);
        chk("timeout_resp_once", bus.pmem_resp, 1'b0);
`else
        seen = 1'b0;
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            seen = seen | bus.pmem_resp;
        end
        chk("no_timeout_resp", seen, 1'b0);
        chk("still_bursting", bus.burst_read, 1'b1);
        chk("err_tied", bus.burst_err, 1'b0);
        bus.pmem_read = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("final_rst_err", bus.burst_err, 1'b0);
        exp_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b1, 1'b0, $urandom, '0, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
